// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator display path.
package calc_display_pkg;

  localparam int unsigned DIGITS      = 8;
  localparam int unsigned BIN_W       = 27;
  localparam int unsigned MAX_DEC     = 99_999_999;
  localparam logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter: load on start, one input bit per shift cycle, MSB first.
module bin2bcd_iter #(
  parameter int unsigned DIGITS = calc_display_pkg::DIGITS,
  parameter int unsigned BIN_W  = calc_display_pkg::BIN_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  shift,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [BIN_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] adj_c;

  // Add 3 to every digit that would overflow past 9 when doubled.
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q <= '0;
      bcd   <= '0;
    end else if (clr) begin
      bin_q <= '0;
      bcd   <= '0;
    end else if (start) begin
      bin_q <= bin_in;
      bcd   <= '0;
    end else if (shift) begin
      bcd   <= {adj_c[4*DIGITS-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/display_controller.sv
// Arbitrates result/entry requests, converts to BCD and holds the committed display image.
module display_controller #(
  parameter int unsigned DIGITS = calc_display_pkg::DIGITS,
  parameter int unsigned BIN_W  = calc_display_pkg::BIN_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [BIN_W-1:0]      res_value,
  input  logic [DIGITS-1:0]     res_dp,
  input  logic                  ent_valid,
  output logic                  ent_ready,
  input  logic [BIN_W-1:0]      ent_value,
  input  logic [DIGITS-1:0]     ent_dp,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   disp_value,
  output logic [DIGITS-1:0]     disp_dp,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  import calc_display_pkg::*;

  localparam int unsigned CNT_W = $clog2(BIN_W);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DIGITS-1:0]   dp_q;
  logic                ovr_q;
  logic                res_xfer_c, ent_xfer_c, start_c, in_range_c, shift_c;
  logic [BIN_W-1:0]    sel_value_c;
  logic [DIGITS-1:0]   sel_dp_c;
  logic [4*DIGITS-1:0] bcd;

  // Result requester wins; neither is accepted while clearing.
  assign res_ready   = (state_q == IDLE) && !clr;
  assign ent_ready   = (state_q == IDLE) && !clr && !res_valid;
  assign res_xfer_c  = res_valid && res_ready;
  assign ent_xfer_c  = ent_valid && ent_ready;
  assign start_c     = res_xfer_c || ent_xfer_c;
  assign sel_value_c = res_xfer_c ? res_value : ent_value;
  assign sel_dp_c    = res_xfer_c ? res_dp : ent_dp;
  assign in_range_c  = sel_value_c <= BIN_W'(MAX_DEC);
  assign shift_c     = (state_q == CONVERT);

  bin2bcd_iter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_conv (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .start  (start_c),
    .shift  (shift_c),
    .bin_in (sel_value_c),
    .bcd    (bcd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_c) state_d = in_range_c ? CONVERT : COMMIT;
      CONVERT: if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // Bit counter and per-request capture of dp mask and overflow flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      dp_q  <= '0;
      ovr_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (start_c) begin
      cnt_q <= '0;
      dp_q  <= sel_dp_c;
      ovr_q <= !in_range_c;
    end else if (state_q == CONVERT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Display image only changes on the edge leaving COMMIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_value <= '0;
      disp_dp    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else if (clr) begin
      disp_value <= '0;
      disp_dp    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= 1'b0;
      if (state_q == COMMIT) begin
        done <= 1'b1;
        if (ovr_q) begin
          disp_value <= {DIGITS{ERR_PATTERN[3:0]}};
          disp_dp    <= '0;
          ovf        <= 1'b1;
        end else begin
          disp_value <= bcd;
          disp_dp    <= dp_q;
          ovf        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_controller.sv
// Directed plus random checks of display_controller against a decimal reference model.
module tb_display_controller;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned BIN_W   = 27;
  localparam int unsigned MAX_DEC = 99_999_999;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               res_valid = 1'b0, ent_valid = 1'b0, clr = 1'b0;
  logic               res_ready, ent_ready;
  logic [BIN_W-1:0]   res_value = '0, ent_value = '0;
  logic [DIGITS-1:0]  res_dp = '0, ent_dp = '0;
  logic [4*DIGITS-1:0] disp_value;
  logic [DIGITS-1:0]  disp_dp;
  logic               busy, done, ovf;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_disp = '0;
  logic [7:0]  m_dp   = '0;
  logic        m_ovf  = 1'b0;

  display_controller #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .resetn(resetn),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value), .res_dp(res_dp),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_value(ent_value), .ent_dp(ent_dp),
    .clr(clr), .disp_value(disp_value), .disp_dp(disp_dp),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // Decimal digits by repeated division, independent of any shift/add scheme.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it until the handshake edge.
  task automatic send(input bit is_res, input int unsigned v, input logic [7:0] dp);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (is_res) begin
      res_valid = 1'b1; res_value = BIN_W'(v); res_dp = dp;
    end else begin
      ent_valid = 1'b1; ent_value = BIN_W'(v); ent_dp = dp;
    end
    for (int k = 0; k < 200 && !ok; k++) begin
      #1;
      ok = is_res ? res_ready : ent_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1;
    res_valid = 1'b0;
    ent_valid = 1'b0;
    check("xfer_ok", 32'(ok), 32'd1);
    check("busy_after_xfer", 32'(busy), 32'd1);
  endtask

  // Called just after the transfer edge; expects the commit exactly at the required latency.
  task automatic expect_commit(input int unsigned v, input logic [7:0] dp, input string tag);
    int unsigned lat;
    bit bad;
    lat = (v > MAX_DEC) ? 1 : 28;
    bad = 1'b0;
    for (int unsigned k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k < lat && (done !== 1'b0 || busy !== 1'b1 || disp_value !== m_disp || disp_dp !== m_dp))
        bad = 1'b1;
    end
    check({tag, "_hold"}, 32'(bad), 32'd0);
    if (v > MAX_DEC) begin
      m_disp = 32'hEEEE_EEEE; m_dp = 8'h00; m_ovf = 1'b1;
    end else begin
      m_disp = to_bcd(v); m_dp = dp; m_ovf = 1'b0;
    end
    check({tag, "_disp"}, disp_value, m_disp);
    check({tag, "_dp"}, 32'(disp_dp), 32'(m_dp));
    check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit          bad;
    bit          is_res;
    int unsigned v;
    logic [7:0]  dp;

    #12;
    check("rst_disp", disp_value, 32'h0);
    check("rst_dp", 32'(disp_dp), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("idle_res_ready", 32'(res_ready), 32'd1);
    check("idle_ent_ready", 32'(ent_ready), 32'd1);

    send(1'b1, 12_345_678, 8'h00);
    expect_commit(12_345_678, 8'h00, "r12345678");
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);

    send(1'b0, 99_999_999, 8'h04);
    expect_commit(99_999_999, 8'h04, "max_dec");
    send(1'b0, 0, 8'h00);
    expect_commit(0, 8'h00, "zero");

    send(1'b1, 100_000_000, 8'hFF);
    expect_commit(100_000_000, 8'hFF, "ovf_min");
    send(1'b1, 42, 8'h01);
    expect_commit(42, 8'h01, "after_ovf");
    send(1'b0, 134_217_727, 8'h10);
    expect_commit(134_217_727, 8'h10, "ovf_max");

    // Simultaneous requests: result first, entry waits.
    @(negedge clk);
    res_valid = 1'b1; res_value = BIN_W'(7); res_dp = 8'h00;
    ent_valid = 1'b1; ent_value = BIN_W'(5); ent_dp = 8'h02;
    #1;
    check("pri_res_ready", 32'(res_ready), 32'd1);
    check("pri_ent_ready", 32'(ent_ready), 32'd0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    bad = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      if (k < 28 && (ent_ready !== 1'b0 || done !== 1'b0)) bad = 1'b1;
    end
    m_disp = to_bcd(7); m_dp = 8'h00; m_ovf = 1'b0;
    check("pri_wait", 32'(bad), 32'd0);
    check("pri_res_disp", disp_value, m_disp);
    check("pri_res_done", 32'(done), 32'd1);
    check("pri_ent_ready_after", 32'(ent_ready), 32'd1);
    @(posedge clk); #1;
    ent_valid = 1'b0;
    check("pri_ent_busy", 32'(busy), 32'd1);
    expect_commit(5, 8'h02, "pri_ent");

    // Clear during conversion, with ovf set beforehand.
    send(1'b1, 123_456_789, 8'h00);
    expect_commit(123_456_789, 8'h00, "ovf_pre_clr");
    send(1'b1, 12_345_678, 8'h80);
    repeat (10) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    ent_valid = 1'b1; ent_value = BIN_W'(321); ent_dp = 8'h08;
    #1;
    check("clr_ent_ready", 32'(ent_ready), 32'd0);
    check("clr_res_ready", 32'(res_ready), 32'd0);
    @(posedge clk); #1;
    m_disp = '0; m_dp = '0; m_ovf = 1'b0;
    check("clr_disp", disp_value, 32'h0);
    check("clr_dp", 32'(disp_dp), 32'h0);
    check("clr_ovf", 32'(ovf), 32'h0);
    check("clr_done", 32'(done), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("post_clr_ent_ready", 32'(ent_ready), 32'd1);
    @(posedge clk); #1;
    ent_valid = 1'b0;
    check("post_clr_busy", 32'(busy), 32'd1);
    expect_commit(321, 8'h08, "post_clr");

    // Asynchronous reset mid-conversion.
    send(1'b0, 87_654_321, 8'h01);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    m_disp = '0; m_dp = '0; m_ovf = 1'b0;
    check("arst_disp", disp_value, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ovf", 32'(ovf), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || disp_value !== 32'h0) bad = 1'b1;
    end
    check("arst_no_commit", 32'(bad), 32'd0);
    send(1'b1, 42, 8'h00);
    expect_commit(42, 8'h00, "after_arst");

    // Randomized requests.
    for (int t = 0; t < 20; t++) begin
      is_res = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) v = $urandom_range(100_000_000, 134_217_727);
      else                           v = $urandom_range(0, 99_999_999);
      dp = 8'($urandom_range(0, 255));
      send(is_res, v, dp);
      expect_commit(v, dp, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 Parameter: DIGITS, default 8, number of decimal digits produced (one 4-bit BCD nibble each).
REQ-002 Parameter: BIN_W, default 27, width of binary input values (enough for 99,999,999).
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: resetn  in  1  asynchronous, active-low reset.
REQ-005 Port: res_valid / res_ready  in / out  1 / 1  result-requester handshake.
REQ-006 Port: res_value / res_dp  in  BIN_W / DIGITS  result binary value and decimal-point mask.
REQ-007 Port: ent_valid / ent_ready  in / out  1 / 1  entry-requester (operand being typed) handshake.
REQ-008 Port: ent_value / ent_dp  in  BIN_W / DIGITS  entry binary value and decimal-point mask.
REQ-009 Port: clr  in  1  synchronous clear-display pulse.
REQ-010 Port: disp_value  out  4*DIGITS  BCD nibbles to the seven-segment driver; nibble 7 is leftmost.
REQ-011 Port: disp_dp  out  DIGITS  decimal-point mask to the driver, 1 = on.
REQ-012 Port: busy / done / ovf  out  1 / 1 / 1  conversion in progress / one-cycle commit pulse / overflow shown.

Function
REQ-013 The FSM SHALL have states IDLE, CONVERT, and COMMIT, encoded in the shared package.
REQ-014 res_ready SHALL be 1 only in IDLE with clr=0.
REQ-015 ent_ready SHALL be 1 only in IDLE with clr=0 and res_valid=0; the result requester has fixed priority.
REQ-016 A transfer SHALL occur on an edge where valid=ready=1; the value and dp mask are captured on that edge and requesters hold their inputs until the transfer.
REQ-017 After a transfer with value <= 99,999,999, the FSM SHALL go IDLE->CONVERT and stay exactly BIN_W cycles using iterative shift-add-3 (double-dabble): one bit per cycle, MSB first.
REQ-018 After a transfer with value > 99,999,999, the FSM SHALL go IDLE->COMMIT directly, skipping CONVERT.
REQ-019 From COMMIT the FSM SHALL always return to IDLE on the next edge.
REQ-020 In COMMIT, disp_value and disp_dp SHALL update together and done SHALL be 1 for exactly that cycle.
REQ-021 Latency: with the transfer on edge N, new outputs SHALL be visible after edge N+28 (in-range) or N+1 (overflow).
REQ-022 On overflow commit, disp_value SHALL be 32'hEEEE_EEEE, disp_dp SHALL be 0, and ovf SHALL be 1.
REQ-023 A valid in-range commit SHALL clear ovf.
REQ-024 busy SHALL be 1 in CONVERT and COMMIT, and 0 in IDLE.
REQ-025 disp_value and disp_dp SHALL hold their last committed contents between commits; no intermediate BCD values appear on outputs.
REQ-026 All digits, including leading zeros, SHALL be displayed (no blanking).
REQ-027 clr=1 SHALL have priority over everything: on the next edge state=IDLE, disp_value=0, disp_dp=0, ovf=0, done=0, and any conversion in progress is discarded.
REQ-028 A request arriving while busy SHALL not be dropped; it is served in IDLE per priority.

Reset
REQ-029 resetn=0 SHALL asynchronously force state=IDLE, disp_value=0, disp_dp=0, busy=0, done=0, and ovf=0, clearing the conversion shift registers.
REQ-030 Reset asserted mid-conversion SHALL abort it with no partial commit.
REQ-031 After reset release, the block SHALL accept requests from the first edge.

Structure
REQ-032 Package calc_display_pkg SHALL hold the FSM state typedef, DIGITS, BIN_W, MAX_DEC=99_999_999, and ERR_PATTERN=32'hEEEE_EEEE.
REQ-033 The iterative converter SHALL be the sub-module bin2bcd_iter (start, BIN_W-cycle shift, bcd out); arbitration, FSM, and output registers stay in display_controller.

Verification
REQ-034 res_value=12,345,678 accepted on edge N -> disp_value=32'h1234_5678, done on edge N+28 only, ovf=0.
REQ-035 ent_value=99,999,999, ent_dp=8'h04 -> disp_value=32'h9999_9999, disp_dp=8'h04; then ent_value=0 -> 32'h0000_0000.
REQ-036 res_value=100,000,000 -> disp_value=32'hEEEE_EEEE and ovf=1 after edge N+1; a subsequent 42 -> 32'h0000_0042 and ovf=0.
REQ-037 res_valid and ent_valid both asserted in IDLE -> result (7) shown first, entry (5) shown second; ent_ready stays 0 until the result transfer completes.
REQ-038 clr pulsed at CONVERT cycle 10 -> outputs 0 on the next edge, no done pulse; a pending ent_valid is accepted on the following edge.
REQ-039 resetn pulled low mid-CONVERT (asynchronously, between edges) -> outputs 0 immediately with no commit; normal operation resumes after release.
